// File: rtl/fft_pkg.sv
// Shared types and derived constants for the in-place radix-2 FFT stage sequencer.
`timescale 1ns/1ps
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } fft_state_e;

  function automatic int fft_n(input int log2n);
    return 1 << log2n;
  endfunction

  function automatic int fft_half_n(input int log2n);
    return 1 << (log2n - 1);
  endfunction

  // Read-to-write distance: memory/ROM read latency plus butterfly latency.
  function automatic int fft_delay(input int rd_lat, input int bf_latency);
    return rd_lat + bf_latency;
  endfunction

  localparam int FFT_LOG2N  = 5;
  localparam int FFT_N      = fft_n(FFT_LOG2N);
  localparam int FFT_HALF_N = fft_half_n(FFT_LOG2N);
  localparam int FFT_D      = fft_delay(1, 8);

endpackage

// File: rtl/clock_delay.sv
// Fixed-depth shift register delaying a bus by DEPTH clock cycles, cleared by clr.
`timescale 1ns/1ps
module clock_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] taps [DEPTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) taps[i] <= '0;
    end else begin
      taps[0] <= d;
      for (int i = 1; i < DEPTH; i++) taps[i] <= taps[i-1];
    end
  end

  assign q = taps[DEPTH-1];

endmodule

// File: rtl/fft_stage_controller.sv
// Issue sequencer for an in-place radix-2 DIT FFT: one butterfly per cycle, stage-by-stage,
// with a drain gap per stage so no read overtakes the previous stage's write-back.
`timescale 1ns/1ps
module fft_stage_controller
  import fft_pkg::*;
#(
  parameter int LOG2N      = 5,
  parameter int RD_LAT     = 1,
  parameter int BF_LATENCY = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(LOG2N)-1:0] stage,
  output logic                     rd_en,
  output logic [LOG2N-1:0]         rd_addr_a,
  output logic [LOG2N-1:0]         rd_addr_b,
  output logic [LOG2N-2:0]         tw_addr,
  output logic                     wr_en,
  output logic [LOG2N-1:0]         wr_addr_a,
  output logic [LOG2N-1:0]         wr_addr_b
);

  localparam int D      = fft_delay(RD_LAT, BF_LATENCY);
  localparam int HALF_N = fft_half_n(LOG2N);
  localparam int SW     = $clog2(LOG2N);
  localparam int KW     = LOG2N - 1;
  localparam int CW     = (D > 1) ? $clog2(D) : 1;
  localparam int PW     = 2 * LOG2N + 1;

  fft_state_e      state_q, state_d;
  logic [SW-1:0]   stage_q, stage_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW-1:0]   drain_q, drain_d;

  logic last_k, last_drain, last_stage;

  assign last_k     = (k_q == KW'(HALF_N - 1));
  assign last_drain = (drain_q == CW'(D - 1));
  assign last_stage = (stage_q == SW'(LOG2N - 1));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      drain_q <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ISSUE;
          stage_d = '0;
          k_d     = '0;
        end
      end
      ST_ISSUE: begin
        k_d = k_q + KW'(1);
        if (last_k) begin
          k_d     = '0;
          drain_d = '0;
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        drain_d = drain_q + CW'(1);
        if (last_drain) begin
          if (!last_stage) begin
            stage_d = stage_q + SW'(1);
            k_d     = '0;
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy  = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign done  = (state_q == ST_DONE);
  assign rd_en = (state_q == ST_ISSUE);
  assign stage = stage_q;

  // Butterfly index k splits into a group and a position within a span of 2^stage.
  logic [LOG2N-1:0] k_ext, span, pos, grp, addr_a, addr_b, tw_full;

  always_comb begin
    k_ext   = {1'b0, k_q};
    span    = LOG2N'(1) << stage_q;
    pos     = k_ext & (span - LOG2N'(1));
    grp     = k_ext >> stage_q;
    addr_a  = (grp << (int'(stage_q) + 1)) | pos;
    addr_b  = addr_a + span;
    tw_full = pos << (LOG2N - 1 - int'(stage_q));
  end

  // Addresses are forced to zero outside ISSUE so idle and write-back buses stay quiet.
  assign rd_addr_a = rd_en ? addr_a : '0;
  assign rd_addr_b = rd_en ? addr_b : '0;
  assign tw_addr   = rd_en ? tw_full[LOG2N-2:0] : '0;

  // p0: issue-side bundle entering the write-back delay line
  logic [PW-1:0] wr_pipe_p0, wr_pipe_pd;

  assign wr_pipe_p0 = {rd_en, rd_addr_a, rd_addr_b};

  clock_delay #(
    .WIDTH (PW),
    .DEPTH (D)
  ) u_wr_delay (
    .clk (clk),
    .clr (clr),
    .d   (wr_pipe_p0),
    .q   (wr_pipe_pd)
  );

  // pd: bundle emerging D cycles later, aligned with butterfly results
  assign {wr_en, wr_addr_a, wr_addr_b} = wr_pipe_pd;

endmodule

// File: tb/tb_fft_stage_controller.sv
// Scoreboard bench for fft_stage_controller: an N=8 instance for sequence/abort checks
// and a default N=32 instance for back-to-back transforms.
`timescale 1ns/1ps
module tb_fft_stage_controller;

  typedef struct {
    int         cyc;
    logic [4:0] a;
    logic [4:0] b;
    logic [3:0] tw;
    int         stg;
  } sb_t;

  logic clk = 1'b0;
  logic clr = 1'b1;
  logic start8 = 1'b0;
  logic start32 = 1'b0;

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  sb_t rd_q[$];
  sb_t wr_q[$];

  logic       busy8, done8, rd_en8, wr_en8;
  logic [1:0] stage8, tw8;
  logic [2:0] rd_a8, rd_b8, wr_a8, wr_b8;

  logic       busy32, done32, rd_en32, wr_en32;
  logic [2:0] stage32;
  logic [3:0] tw32;
  logic [4:0] rd_a32, rd_b32, wr_a32, wr_b32;

  fft_stage_controller #(.LOG2N(3), .RD_LAT(1), .BF_LATENCY(8)) dut8 (
    .clk(clk), .clr(clr), .start(start8), .busy(busy8), .done(done8), .stage(stage8),
    .rd_en(rd_en8), .rd_addr_a(rd_a8), .rd_addr_b(rd_b8), .tw_addr(tw8),
    .wr_en(wr_en8), .wr_addr_a(wr_a8), .wr_addr_b(wr_b8)
  );

  fft_stage_controller dut32 (
    .clk(clk), .clr(clr), .start(start32), .busy(busy32), .done(done32), .stage(stage32),
    .rd_en(rd_en32), .rd_addr_a(rd_a32), .rd_addr_b(rd_b32), .tw_addr(tw32),
    .wr_en(wr_en32), .wr_addr_a(wr_a32), .wr_addr_b(wr_b32)
  );

  // Reference butterfly: operand a = group*2*span + position, twiddle stride HALF_N/span.
  function automatic sb_t model(input int log2n, input int s, input int k, input int cyc);
    sb_t m;
    int span, hn, av;
    span  = 1 << s;
    hn    = 1 << (log2n - 1);
    av    = (k / span) * 2 * span + (k % span);
    m.cyc = cyc;
    m.a   = 5'(av);
    m.b   = 5'(av + span);
    m.tw  = 4'((k % span) * (hn / span));
    m.stg = s;
    return m;
  endfunction

  task automatic test_reset();
    start8  = 1'b1;
    start32 = 1'b1;
    clr     = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({busy8, done8, rd_en8, wr_en8, stage8, rd_a8, rd_b8, tw8, wr_a8, wr_b8} !== '0) begin
      bad++;
      $display("FAIL reset_outputs8 got=%h want=0",
               {busy8, done8, rd_en8, wr_en8, stage8, rd_a8, rd_b8, tw8, wr_a8, wr_b8});
    end
    total++;
    if ({busy32, done32, rd_en32, wr_en32, stage32, rd_a32, rd_b32, tw32, wr_a32, wr_b32} !== '0) begin
      bad++;
      $display("FAIL reset_outputs32 got=%h want=0",
               {busy32, done32, rd_en32, wr_en32, stage32, rd_a32, rd_b32, tw32, wr_a32, wr_b32});
    end
    start8  = 1'b0;
    start32 = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      total++;
      if ({busy8, rd_en8, busy32, rd_en32} !== 4'b0000) begin
        bad++;
        $display("FAIL idle_after_reset got=%b want=0000", {busy8, rd_en8, busy32, rd_en32});
      end
    end
  endtask

  task automatic test_transform8(input bit pester);
    sb_t        e;
    int         busy_n, done_n;
    int         last_wr [3];
    logic [6:0] hist [64];
    logic [4:0] ga, gb, gs;
    logic [3:0] gt;
    bit         exp_rd, exp_wr;
    rd_q.delete();
    wr_q.delete();
    for (int s = 0; s < 3; s++) begin
      for (int k = 0; k < 4; k++) begin
        e = model(3, s, k, s * 13 + k + 1);
        rd_q.push_back(e);
        e.cyc += 9;
        wr_q.push_back(e);
      end
    end
    for (int i = 0; i < 3; i++) last_wr[i] = -1;
    busy_n = 0;
    done_n = 0;
    @(negedge clk);
    start8 = 1'b1;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      start8 = pester && (c <= 40) && ((c % 3 == 0) || (c == 40));
      if (busy8) busy_n++;
      if (done8) done_n++;
      total++;
      if (busy8 !== (c <= 39)) begin
        bad++;
        $display("FAIL busy8 c=%0d got=%b want=%b", c, busy8, (c <= 39));
      end
      total++;
      if (done8 !== (c == 40)) begin
        bad++;
        $display("FAIL done8 c=%0d got=%b want=%b", c, done8, (c == 40));
      end
      exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == c);
      total++;
      if (rd_en8 !== exp_rd) begin
        bad++;
        $display("FAIL rd_en8 c=%0d got=%b want=%b", c, rd_en8, exp_rd);
      end else if (exp_rd) begin
        e  = rd_q.pop_front();
        ga = {2'b00, rd_a8};
        gb = {2'b00, rd_b8};
        gt = {2'b00, tw8};
        gs = {3'b000, stage8};
        total++;
        if ({ga, gb, gt, gs} !== {e.a, e.b, e.tw, 5'(e.stg)}) begin
          bad++;
          $display("FAIL rd_pair8 c=%0d got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                   c, ga, gb, gt, gs, e.a, e.b, e.tw, e.stg);
        end
        if (e.stg > 0) begin
          total++;
          if (c <= last_wr[e.stg-1]) begin
            bad++;
            $display("FAIL hazard8 c=%0d got read_cycle=%0d want after=%0d", c, c, last_wr[e.stg-1]);
          end
        end
      end
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == c);
      total++;
      if (wr_en8 !== exp_wr) begin
        bad++;
        $display("FAIL wr_en8 c=%0d got=%b want=%b", c, wr_en8, exp_wr);
      end else if (exp_wr) begin
        e  = wr_q.pop_front();
        ga = {2'b00, wr_a8};
        gb = {2'b00, wr_b8};
        total++;
        if ({ga, gb} !== {e.a, e.b}) begin
          bad++;
          $display("FAIL wr_pair8 c=%0d got a=%0d b=%0d want a=%0d b=%0d", c, ga, gb, e.a, e.b);
        end
        last_wr[e.stg] = c;
      end
      hist[c] = {rd_en8, rd_a8, rd_b8};
      if (c > 9) begin
        total++;
        if ({wr_en8, wr_a8, wr_b8} !== hist[c-9]) begin
          bad++;
          $display("FAIL wr_align8 c=%0d got=%h want=%h", c, {wr_en8, wr_a8, wr_b8}, hist[c-9]);
        end
      end
    end
    start8 = 1'b0;
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left8 got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size());
    end
    total++;
    if (busy_n != 39) begin
      bad++;
      $display("FAIL busy_len8 got=%0d want=39", busy_n);
    end
    total++;
    if (done_n != 1) begin
      bad++;
      $display("FAIL done_count8 got=%0d want=1", done_n);
    end
  endtask

  task automatic test_abort();
    @(negedge clk);
    start8 = 1'b1;
    for (int c = 1; c <= 23; c++) begin
      @(negedge clk);
      start8 = 1'b0;
    end
    total++;
    if ({busy8, rd_en8, wr_en8, stage8} !== 5'b10101) begin
      bad++;
      $display("FAIL abort_pre got=%b want=10101", {busy8, rd_en8, wr_en8, stage8});
    end
    #1 clr = 1'b1;
    #1;
    total++;
    if ({busy8, done8, rd_en8, wr_en8} !== 4'b0000) begin
      bad++;
      $display("FAIL abort_drop got=%b want=0000", {busy8, done8, rd_en8, wr_en8});
    end
    @(negedge clk);
    clr = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      total++;
      if ({busy8, done8, wr_en8} !== 3'b000) begin
        bad++;
        $display("FAIL abort_quiet c=%0d got=%b want=000", c, {busy8, done8, wr_en8});
      end
    end
  endtask

  task automatic test_back_to_back();
    sb_t e;
    int  done_n;
    bit  exp_rd, exp_wr, exp_busy, exp_done;
    rd_q.delete();
    wr_q.delete();
    for (int t = 0; t < 2; t++) begin
      for (int s = 0; s < 5; s++) begin
        for (int k = 0; k < 16; k++) begin
          e = model(5, s, k, t * 127 + s * 25 + k + 1);
          rd_q.push_back(e);
          e.cyc += 9;
          wr_q.push_back(e);
        end
      end
    end
    done_n = 0;
    @(negedge clk);
    start32 = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      start32 = (c == 50) || (c == 126) || (c == 127);
      if (done32) done_n++;
      exp_busy = (c <= 125) || (c >= 128 && c <= 252);
      exp_done = (c == 126) || (c == 253);
      total++;
      if ({busy32, done32} !== {exp_busy, exp_done}) begin
        bad++;
        $display("FAIL busy_done32 c=%0d got=%b want=%b", c, {busy32, done32}, {exp_busy, exp_done});
      end
      exp_rd = (rd_q.size() > 0) && (rd_q[0].cyc == c);
      total++;
      if (rd_en32 !== exp_rd) begin
        bad++;
        $display("FAIL rd_en32 c=%0d got=%b want=%b", c, rd_en32, exp_rd);
      end else if (exp_rd) begin
        e = rd_q.pop_front();
        total++;
        if ({rd_a32, rd_b32, tw32, stage32} !== {e.a, e.b, e.tw, 3'(e.stg)}) begin
          bad++;
          $display("FAIL rd_pair32 c=%0d got a=%0d b=%0d tw=%0d st=%0d want a=%0d b=%0d tw=%0d st=%0d",
                   c, rd_a32, rd_b32, tw32, stage32, e.a, e.b, e.tw, e.stg);
        end
      end
      exp_wr = (wr_q.size() > 0) && (wr_q[0].cyc == c);
      total++;
      if (wr_en32 !== exp_wr) begin
        bad++;
        $display("FAIL wr_en32 c=%0d got=%b want=%b", c, wr_en32, exp_wr);
      end else if (exp_wr) begin
        e = wr_q.pop_front();
        total++;
        if ({wr_a32, wr_b32} !== {e.a, e.b}) begin
          bad++;
          $display("FAIL wr_pair32 c=%0d got a=%0d b=%0d want a=%0d b=%0d", c, wr_a32, wr_b32, e.a, e.b);
        end
      end
    end
    start32 = 1'b0;
    total++;
    if (rd_q.size() != 0 || wr_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left32 got rd=%0d wr=%0d want 0 0", rd_q.size(), wr_q.size());
    end
    total++;
    if (done_n != 2) begin
      bad++;
      $display("FAIL done_count32 got=%0d want=2", done_n);
    end
  endtask

  initial begin
    test_reset();
    test_transform8(1'b0);
    test_abort();
    test_transform8(1'b0);
    test_transform8(1'b1);
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_controller.md
# fft_stage_controller

Sequencer for an in-place radix-2 decimation-in-time FFT built around one pipelined butterfly unit. It generates the read address pair and twiddle index for one butterfly per cycle across all stages. It delays those addresses to produce matching write-back addresses. Between stages it holds off issue until the butterfly pipeline has drained, so no stage reads data the previous stage has not yet written.

## Interface
- LOG2N, 5: log2 of transform size; N = 2^LOG2N points, N/2 butterflies per stage, LOG2N stages.
- RD_LAT, 1: cycles from rd_en/addresses to valid data on the data memory and twiddle ROM outputs.
- BF_LATENCY, 8: butterfly unit input-to-output latency in cycles.
- clk  input  1  single clock, all logic on rising edge.
- clr  input  1  asynchronous, active-high reset.
- start  input  1  begin a transform; sampled only in IDLE.
- busy  output  1  high during ISSUE and DRAIN.
- done  output  1  one-cycle pulse when the final write of the final stage has completed.
- stage  output  $clog2(LOG2N)  current stage index, 0..LOG2N-1.
- rd_en  output  1  read strobe for the data memory and twiddle ROM.
- rd_addr_a, rd_addr_b  output  LOG2N  butterfly operand addresses.
- tw_addr  output  LOG2N-1  twiddle ROM index.
- wr_en  output  1  write strobe for butterfly results.
- wr_addr_a, wr_addr_b  output  LOG2N  write-back addresses, equal to the read addresses delayed D = RD_LAT + BF_LATENCY cycles.

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, stage←0, k←0, go to ISSUE. start in any other state is ignored.
- ISSUE: rd_en=1 each cycle and k increments. For span = 2^stage, pos = k & (span-1), group = k >> stage:
  - rd_addr_a = (group << (stage+1)) | pos
  - rd_addr_b = rd_addr_a + span
  - tw_addr = pos << (LOG2N-1-stage)
  - After the cycle with k = N/2-1, reset the drain counter and go to DRAIN.
- DRAIN: rd_en=0; count D cycles. At the end of the count:
  - if stage < LOG2N-1: stage++, k←0, go to ISSUE;
  - else go to DONE.
- DONE: done=1 for one cycle, busy=0, then go to IDLE.
- Write path: a D-deep shift pipeline carries {valid, addr_a, addr_b}. wr_en and wr_addr_* are its output. wr_en is never high in IDLE or DONE.
- All arithmetic is unsigned, and addresses are truncated to LOG2N bits, with no wrap beyond N-1.
- Input data must already be in bit-reversed order; output is in natural order.

## Timing
- Reset values: busy=0, done=0, rd_en=0, wr_en=0, stage=0, and all address outputs 0. The pipeline valid bits are cleared.
- When clr is asserted mid-transform, the controller aborts immediately to IDLE. No done pulse is produced and no further wr_en is issued.
- start is sampled at edge t0. The first rd_en is in the cycle following t0.
- A butterfly issued in cycle c is written in cycle c+D.
- The last write of each stage lands in the last DRAIN cycle. The next stage's first read follows in the next cycle, so there is no read-after-write hazard.
- busy is high for exactly LOG2N·(N/2 + D) consecutive cycles. done follows in the next cycle.
- start asserted in the same cycle as done (DONE state) is ignored. It is accepted only in IDLE.

## Structure
- Shared package `fft_pkg`: FSM state enum, the derived constants N and HALF_N, and the D = RD_LAT+BF_LATENCY helper.
- Reuse the codebase's existing `clock_delay` as the sub-module for the write-address/valid pipeline. Width is 2·LOG2N+1, depth is D, and the clr input is tied to the aborting reset path.
- The address generator stays inline; it is purely combinational from stage and k.

## Test plan
- Reset: assert clr with start held high → all outputs 0, FSM stays in IDLE until clr is released and start is seen.
- LOG2N=3, defaults (D=9), pulse start → stage 0 read pairs (0,1),(2,3),(4,5),(6,7) with tw 0,0,0,0.
  - Stage 1 → pairs (0,2),(1,3),(4,6),(5,7) with tw 0,2,0,2.
  - Stage 2 → pairs (0,4),(1,5),(2,6),(3,7) with tw 0,1,2,3.
- Same run → busy high for 39 cycles; done pulses exactly once, in cycle 40 after start is sampled.
- Write alignment: every wr_en/wr_addr_* equals the rd_en/rd_addr_* from 9 cycles earlier. No rd_en of stage s+1 occurs before the last wr_en of stage s.
- Abort: assert clr during stage 1 DRAIN → wr_en drops the next cycle, done never pulses. A new start then runs a full clean 39-cycle transform.
- Pulse start repeatedly while busy and during DONE → no restart and no change in address sequence. The scoreboard matches a software model of the N=32 default configuration over two back-to-back transforms.
